// File: rtl/ex_div.sv
// Multi-cycle restoring divider for the EX stage (DIV/DIVU).
// Produces {remainder, quotient}; one quotient bit per cycle.
module ex_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned DVD_W = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [DVD_W-1:0]   dvd, dvd_n;
  logic [WIDTH-1:0]   dvs, dvs_n;
  logic               sgn, sgn_n;
  logic               neg1, neg1_n;
  logic               neg2, neg2_n;
  logic [2*WIDTH-1:0] result_n;
  logic               ready_n;

  logic [WIDTH-1:0]   abs1_c, abs2_c;
  logic [WIDTH:0]     trial_c;
  logic [WIDTH-1:0]   quo_c, rem_c;

  // Magnitudes of the operands; the most negative value stays as-is and reads as unsigned.
  assign abs1_c = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
  assign abs2_c = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

  assign trial_c = {1'b0, dvd[2*WIDTH-1:WIDTH]} - {1'b0, dvs};

  // Sign fix-up: quotient sign from operand signs, remainder follows the dividend.
  assign quo_c = (sgn && (neg1 ^ neg2)) ? (~dvd[WIDTH-1:0] + WIDTH'(1)) : dvd[WIDTH-1:0];
  assign rem_c = (sgn && neg1) ? (~dvd[2*WIDTH:WIDTH+1] + WIDTH'(1)) : dvd[2*WIDTH:WIDTH+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FREE;
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      sgn      <= 1'b0;
      neg1     <= 1'b0;
      neg2     <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      dvd      <= dvd_n;
      dvs      <= dvs_n;
      sgn      <= sgn_n;
      neg1     <= neg1_n;
      neg2     <= neg2_n;
      result_o <= result_n;
      ready_o  <= ready_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    dvd_n    = dvd;
    dvs_n    = dvs;
    sgn_n    = sgn;
    neg1_n   = neg1;
    neg2_n   = neg2;
    result_n = result_o;
    ready_n  = ready_o;

    case (state)
      S_FREE: begin
        ready_n  = 1'b0;
        result_n = '0;
        if (start_i && !annul_i) begin
          sgn_n  = signed_div_i;
          neg1_n = opdata1_i[WIDTH-1];
          neg2_n = opdata2_i[WIDTH-1];
          dvd_n  = {WIDTH'(0), abs1_c, 1'b0};
          dvs_n  = abs2_c;
          cnt_n  = '0;
          state_n = (opdata2_i == '0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: begin
        result_n = '0;
        ready_n  = 1'b1;
        state_n  = S_END;
      end
      S_ON: begin
        if (annul_i) begin
          ready_n  = 1'b0;
          result_n = '0;
          state_n  = S_FREE;
        end else if (cnt < CNT_W'(WIDTH)) begin
          // Restoring step: keep the shifted partial remainder if the trial went negative.
          if (trial_c[WIDTH]) begin
            dvd_n = {dvd[2*WIDTH-1:0], 1'b0};
          end else begin
            dvd_n = {trial_c[WIDTH-1:0], dvd[WIDTH-1:0], 1'b1};
          end
          cnt_n = cnt + CNT_W'(1);
        end else begin
          result_n = {rem_c, quo_c};
          ready_n  = 1'b1;
          state_n  = S_END;
        end
      end
      S_END: begin
        if (!start_i) begin
          ready_n  = 1'b0;
          result_n = '0;
          state_n  = S_FREE;
        end
      end
      default: begin
        state_n = S_FREE;
      end
    endcase
  end

endmodule

// File: tb/tb_ex_div.sv
// Directed testbench for ex_div: hand-computed quotient/remainder vectors,
// latency, annul, divide-by-zero and asynchronous reset behaviour.
module tb_ex_div;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int checks = 0;
  int errors = 0;

  ex_div #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Edges counted from the accept edge E0 inclusive: ready after E33 -> 34, after E1 -> 2.
  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp,
                        input int exp_edges, input bit scramble);
    int edges;
    @(negedge clk);
    signed_div = s; op1 = a; op2 = b; start = 1'b1;
    @(negedge clk);
    edges = 1;
    if (scramble) begin
      op1 = 32'hDEAD_BEEF; op2 = 32'h0; signed_div = ~s;
    end
    while (!ready && edges < 60) begin
      @(negedge clk);
      edges++;
    end
    check({tag, " latency"}, 64'(edges), 64'(exp_edges));
    check({tag, " result"}, result, exp);
    @(negedge clk);
    check({tag, " hold ready"}, 64'(ready), 64'd1);
    check({tag, " hold result"}, result, exp);
    start = 1'b0;
    @(negedge clk);
    check({tag, " release ready"}, 64'(ready), 64'd0);
    check({tag, " release result"}, result, 64'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; signed_div = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
    repeat (2) @(negedge clk);
    check("reset ready", 64'(ready), 64'd0);
    check("reset result", result, 64'd0);
    rst = 1'b0;

    run_op("udiv 100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, 1'b0);
    run_op("sdiv -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34, 1'b0);
    run_op("sdiv 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34, 1'b0);
    run_op("sdiv -100/-7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 34, 1'b0);
    run_op("div by zero", 1'b0, 32'h1234, 32'd0, 64'h0, 2, 1'b0);
    run_op("sdiv overflow", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34, 1'b0);
    run_op("udiv max/1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 34, 1'b0);
    run_op("udiv 0x80000000/3", 1'b0, 32'h80000000, 32'd3, 64'h00000002_2AAAAAAA, 34, 1'b0);
    run_op("operand change", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, 1'b1);

    // Annul at cnt = 10 while start stays high: no result, and start+annul is not accepted.
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    repeat (11) @(negedge clk);
    annul = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0; annul = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) seen++;
    end
    check("annul no ready", 64'(seen), 64'd0);
    run_op("after annul 9/3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34, 1'b0);

    // Async reset at cnt = 20 clears outputs with no clock edge.
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    repeat (21) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst mid ready", 64'(ready), 64'd0);
    check("rst mid result", result, 64'd0);
    #1 rst = 1'b0; start = 1'b0;
    run_op("after reset 9/3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34, 1'b0);

    // Async reset while a result is being held clears it immediately.
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd50; op2 = 32'd8; start = 1'b1;
    seen = 0;
    while (!ready && seen < 60) begin
      @(negedge clk);
      seen++;
    end
    check("pre-rst result", result, 64'h00000002_00000006);
    #1 rst = 1'b1;
    #1;
    check("rst end ready", 64'(ready), 64'd0);
    check("rst end result", result, 64'd0);
    #1 rst = 1'b0; start = 1'b0;
    run_op("final 100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
